// File: rtl/toubi_pkg.sv
// Shared definitions for the ticket-machine payment controller.
//   - state_e    : controller FSM states
//   - PRICE_W    : width of fare / money values (yuan)
//   - COIN*_VAL  : value of each coin slot
//   - sel_valid(): legal ticket-type / quantity check
package toubi_pkg;

  localparam int unsigned PRICE_W    = 6;
  localparam int unsigned COIN1_VAL  = 1;
  localparam int unsigned COIN5_VAL  = 5;
  localparam int unsigned TICKET_MIN = 1;
  localparam int unsigned TICKET_MAX = 4;
  localparam int unsigned COUNT_MIN  = 1;
  localparam int unsigned COUNT_MAX  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StPay,
    StIssue,
    StChange
  } state_e;

  // Compared at 32 bits so the limits stay meaningful if the fields are widened.
  function automatic logic sel_valid(logic [2:0] ticket, logic [2:0] count);
    return (32'(ticket) >= TICKET_MIN) && (32'(ticket) <= TICKET_MAX) &&
           (32'(count) >= COUNT_MIN) && (32'(count) <= COUNT_MAX);
  endfunction

endpackage

// File: rtl/toubi_if.sv
// Passenger-facing and dispense-facing signal bundle of toubi_ctrl.
//   master : passenger panel / coin acceptor side (drives sel, coins, cancel)
//   slave  : toubi_ctrl side (drives en, ticket, count, due, paid, change, strobes)
interface toubi_if;
  import toubi_pkg::*;

  logic               sel;
  logic [2:0]         ticket_in;
  logic [2:0]         count_in;
  logic               coin1;
  logic               coin5;
  logic               cancel;
  logic               en;
  logic [2:0]         ticket;
  logic [2:0]         count;
  logic [PRICE_W-1:0] due;
  logic [PRICE_W-1:0] paid;
  logic [PRICE_W-1:0] change;
  logic               change_vld;
  logic               coin_rej;
  logic               sel_err;
  logic               busy;

  modport master (
    output sel, ticket_in, count_in, coin1, coin5, cancel,
    input  en, ticket, count, due, paid, change, change_vld, coin_rej, sel_err, busy
  );

  modport slave (
    input  sel, ticket_in, count_in, coin1, coin5, cancel,
    output en, ticket, count, due, paid, change, change_vld, coin_rej, sel_err, busy
  );

endinterface

// File: rtl/toubi_price.sv
// Fare lookup: unit price of the ticket type multiplied by quantity.
//   ticket_i : ticket type (1..4; anything else prices at 0)
//   count_i  : quantity
//   fare_o   : price * count, PRICE_W bits
module toubi_price
  import toubi_pkg::*;
#(
  parameter int unsigned PRICE1 = 1,
  parameter int unsigned PRICE2 = 2,
  parameter int unsigned PRICE3 = 3,
  parameter int unsigned PRICE4 = 5
) (
  input  logic [2:0]         ticket_i,
  input  logic [2:0]         count_i,
  output logic [PRICE_W-1:0] fare_o
);

  logic [PRICE_W-1:0] price;

  always_comb begin
    price = '0;
    case (ticket_i)
      3'd1:    price = PRICE_W'(PRICE1);
      3'd2:    price = PRICE_W'(PRICE2);
      3'd3:    price = PRICE_W'(PRICE3);
      3'd4:    price = PRICE_W'(PRICE4);
      default: price = '0;
    endcase
  end

  assign fare_o = price * PRICE_W'(count_i);

endmodule

// File: rtl/toubi_ctrl.sv
// Payment controller: latches the selection, accumulates coins, pulses en to the
// dispenser, then reports change (or a full refund on cancel).
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : toubi_if.slave (selection, coins, cancel in; en/ticket/count/due/paid/
//          change/change_vld/coin_rej/sel_err/busy out, all registered)
// Optional: define TOUBI_TIMEOUT_EN to refund automatically after TIMEOUT_CYC
// coin-less cycles in PAY.
module toubi_ctrl
  import toubi_pkg::*;
#(
  parameter int unsigned PRICE1      = 1,
  parameter int unsigned PRICE2      = 2,
  parameter int unsigned PRICE3      = 3,
  parameter int unsigned PRICE4      = 5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic    clk,
  input logic    rst,
  toubi_if.slave bus
);

  state_e             state_q;
  logic               en_q, change_vld_q, coin_rej_q, sel_err_q, busy_q;
  logic [2:0]         ticket_q, count_q;
  logic [PRICE_W-1:0] due_q, paid_q, change_q;

  logic [PRICE_W-1:0] fare, coin_add, paid_sum;
  logic               coin_any, refund;

  toubi_price #(
    .PRICE1 (PRICE1),
    .PRICE2 (PRICE2),
    .PRICE3 (PRICE3),
    .PRICE4 (PRICE4)
  ) u_price (
    .ticket_i (bus.ticket_in),
    .count_i  (bus.count_in),
    .fare_o   (fare)
  );

  assign coin_any = bus.coin1 | bus.coin5;
  assign coin_add = (bus.coin1 ? PRICE_W'(COIN1_VAL) : '0) +
                    (bus.coin5 ? PRICE_W'(COIN5_VAL) : '0);
  // Cannot overflow: paid stays below due (<= 35) before the last coin adds at most 6.
  assign paid_sum = paid_q + coin_add;

`ifdef TOUBI_TIMEOUT_EN
  logic [31:0] tmr_q;
  logic        timeout;
  assign timeout = (state_q == StPay) && !coin_any && (tmr_q == TIMEOUT_CYC - 1);

  // Counts coin-less cycles in PAY; cleared on entry and on every accepted coin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
    end else if (state_q != StPay || coin_any) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 32'd1;
    end
  end
`else
  logic timeout;
  logic unused_timeout_cyc;
  assign timeout            = 1'b0;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // A coin with cancel is counted first, then refunded together with the rest.
  assign refund = bus.cancel | timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      en_q         <= 1'b0;
      change_vld_q <= 1'b0;
      coin_rej_q   <= 1'b0;
      sel_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      ticket_q     <= '0;
      count_q      <= '0;
      due_q        <= '0;
      paid_q       <= '0;
      change_q     <= '0;
    end else begin
      en_q         <= 1'b0;
      change_vld_q <= 1'b0;
      coin_rej_q   <= 1'b0;
      sel_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          coin_rej_q <= coin_any;
          if (bus.sel) begin
            if (sel_valid(bus.ticket_in, bus.count_in)) begin
              ticket_q <= bus.ticket_in;
              count_q  <= bus.count_in;
              due_q    <= fare;
              paid_q   <= '0;
              busy_q   <= 1'b1;
              state_q  <= StPay;
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        StPay: begin
          paid_q <= paid_sum;
          if (refund) begin
            change_q     <= paid_sum;
            change_vld_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end else if (paid_sum >= due_q) begin
            en_q    <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          coin_rej_q   <= coin_any;
          change_q     <= paid_q - due_q;
          change_vld_q <= 1'b1;
          state_q      <= StChange;
        end
        StChange: begin
          coin_rej_q <= coin_any;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.en         = en_q;
  assign bus.ticket     = ticket_q;
  assign bus.count      = count_q;
  assign bus.due        = due_q;
  assign bus.paid       = paid_q;
  assign bus.change     = change_q;
  assign bus.change_vld = change_vld_q;
  assign bus.coin_rej   = coin_rej_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_toubi_ctrl.sv
// Directed, table-driven bench for toubi_ctrl: one vector per clock, outputs
// sampled 1 ns after the rising edge, plus hand-written reset and timeout sequences.
module tb_toubi_ctrl;

  typedef struct packed {
    logic       sel;
    logic [2:0] tk;
    logic [2:0] ct;
    logic       c1;
    logic       c5;
    logic       cx;
  } in_t;

  typedef struct packed {
    logic       en;
    logic [2:0] tk;
    logic [2:0] ct;
    logic [5:0] due;
    logic [5:0] paid;
    logic [5:0] chg;
    logic       cv;
    logic       rej;
    logic       serr;
    logic       busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  toubi_if bus ();

  toubi_ctrl #(
    .PRICE1      (1),
    .PRICE2      (2),
    .PRICE3      (3),
    .PRICE4      (5),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(logic sel, int tk, int ct, logic c1, logic c5, logic cx);
    in_t r;
    r = '{sel: sel, tk: 3'(tk), ct: 3'(ct), c1: c1, c5: c5, cx: cx};
    return r;
  endfunction

  function automatic out_t mo(logic en, int tk, int ct, int due, int paid, int chg,
                              logic cv, logic rej, logic serr, logic busy);
    out_t r;
    r = '{en: en, tk: 3'(tk), ct: 3'(ct), due: 6'(due), paid: 6'(paid), chg: 6'(chg),
          cv: cv, rej: rej, serr: serr, busy: busy};
    return r;
  endfunction

  task automatic drive(input in_t i);
    bus.sel       = i.sel;
    bus.ticket_in = i.tk;
    bus.count_in  = i.ct;
    bus.coin1     = i.c1;
    bus.coin5     = i.c5;
    bus.cancel    = i.cx;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {bus.en, bus.ticket, bus.count, bus.due, bus.paid, bus.change,
           bus.change_vld, bus.coin_rej, bus.sel_err, bus.busy};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got en=%0b tk=%0d ct=%0d due=%0d paid=%0d chg=%0d cv=%0b rej=%0b serr=%0b busy=%0b | want en=%0b tk=%0d ct=%0d due=%0d paid=%0d chg=%0d cv=%0b rej=%0b serr=%0b busy=%0b",
               name, act.en, act.tk, act.ct, act.due, act.paid, act.chg, act.cv, act.rej,
               act.serr, act.busy, exp.en, exp.tk, exp.ct, exp.due, exp.paid, exp.chg,
               exp.cv, exp.rej, exp.serr, exp.busy);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input string name, input in_t i, input out_t exp);
    @(negedge clk);
    drive(i);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    drive(mi(0, 0, 0, 0, 0, 0));

    // in: sel tk ct c1 c5 cx | out: en tk ct due paid chg cv rej serr busy
    // invalid selections and idle coins/cancel
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{mi(1, 0, 3, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mi(1, 1, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mi(1, 5, 1, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    // type 2 x2, due 4, coin5 -> change 1
    vecs.push_back('{mi(1, 2, 2, 0, 0, 0), mo(0, 2, 2, 4, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 1, 0), mo(1, 2, 2, 4, 5, 0, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 2, 2, 4, 5, 1, 1, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 2, 2, 4, 5, 1, 0, 0, 0, 0)});
    // type 3 x3, due 9, 4x coin1 (sel ignored in PAY) then coin5 -> change 0
    vecs.push_back('{mi(1, 3, 3, 0, 0, 0), mo(0, 3, 3, 9, 0, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 0), mo(0, 3, 3, 9, 1, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(1, 1, 1, 1, 0, 0), mo(0, 3, 3, 9, 2, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 0), mo(0, 3, 3, 9, 3, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 0), mo(0, 3, 3, 9, 4, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 3, 3, 9, 4, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 1, 0), mo(1, 3, 3, 9, 9, 1, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 3, 3, 9, 9, 0, 1, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 3, 3, 9, 9, 0, 0, 0, 0, 0)});
    // type 4 x7, due 35, both coins at once then cancel -> refund 6
    vecs.push_back('{mi(1, 4, 7, 0, 0, 0), mo(0, 4, 7, 35, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 1, 0), mo(0, 4, 7, 35, 6, 0, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 1), mo(0, 4, 7, 35, 6, 6, 1, 0, 0, 0)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 4, 7, 35, 6, 6, 0, 0, 0, 0)});
    // coins in ISSUE and CHANGE are rejected; cancel in CHANGE ignored
    vecs.push_back('{mi(1, 1, 1, 0, 0, 0), mo(0, 1, 1, 1, 0, 6, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 0), mo(1, 1, 1, 1, 1, 6, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 0, 1, 0), mo(0, 1, 1, 1, 1, 0, 1, 1, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 1), mo(0, 1, 1, 1, 1, 0, 0, 1, 0, 0)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 1, 1, 1, 1, 0, 0, 0, 0, 0)});
    // cancel beats a coin that would have completed payment
    vecs.push_back('{mi(1, 1, 2, 0, 0, 0), mo(0, 1, 2, 2, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 0), mo(0, 1, 2, 2, 1, 0, 0, 0, 0, 1)});
    vecs.push_back('{mi(0, 0, 0, 1, 0, 1), mo(0, 1, 2, 2, 2, 2, 1, 0, 0, 0)});
    vecs.push_back('{mi(0, 0, 0, 0, 0, 0), mo(0, 1, 2, 2, 2, 2, 0, 0, 0, 0)});

    #3;
    check("reset", mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      step($sformatf("vec%0d", k), vecs[k].i, vecs[k].o);
    end

    // asynchronous reset in the middle of PAY with paid = 3
    step("rst_sel", mi(1, 4, 7, 0, 0, 0), mo(0, 4, 7, 35, 0, 2, 0, 0, 0, 1));
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("rst_coin%0d", k), mi(0, 0, 0, 1, 0, 0), mo(0, 4, 7, 35, k, 2, 0, 0, 0, 1));
    end
    drive(mi(0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    step("post_rst_sel", mi(1, 4, 1, 0, 0, 0), mo(0, 4, 1, 5, 0, 0, 0, 0, 0, 1));
    step("post_rst_c5", mi(0, 0, 0, 0, 1, 0), mo(1, 4, 1, 5, 5, 0, 0, 0, 0, 1));
    step("post_rst_chg", mi(0, 0, 0, 0, 0, 0), mo(0, 4, 1, 5, 5, 0, 1, 0, 0, 1));
    step("post_rst_idle", mi(0, 0, 0, 0, 0, 0), mo(0, 4, 1, 5, 5, 0, 0, 0, 0, 0));

    // type 1 x5, one coin, then wait without coins
    step("to_sel", mi(1, 1, 5, 0, 0, 0), mo(0, 1, 5, 5, 0, 0, 0, 0, 0, 1));
    step("to_coin", mi(0, 0, 0, 1, 0, 0), mo(0, 1, 5, 5, 1, 0, 0, 0, 0, 1));
`ifdef TOUBI_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      step($sformatf("to_wait%0d", k), mi(0, 0, 0, 0, 0, 0), mo(0, 1, 5, 5, 1, 0, 0, 0, 0, 1));
    end
    step("to_refund", mi(0, 0, 0, 0, 0, 0), mo(0, 1, 5, 5, 1, 1, 1, 0, 0, 0));
    step("to_idle", mi(0, 0, 0, 0, 0, 0), mo(0, 1, 5, 5, 1, 1, 0, 0, 0, 0));
`else
    for (int k = 1; k <= 20; k++) begin
      step($sformatf("no_to_wait%0d", k), mi(0, 0, 0, 0, 0, 0),
           mo(0, 1, 5, 5, 1, 0, 0, 0, 0, 1));
    end
    step("no_to_cancel", mi(0, 0, 0, 0, 0, 1), mo(0, 1, 5, 5, 1, 1, 1, 0, 0, 0));
    step("no_to_idle", mi(0, 0, 0, 0, 0, 0), mo(0, 1, 5, 5, 1, 1, 0, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
